// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Purpose  : Parallel-to-serial converter that feeds the serial "101"
//            sequence detector. It accepts WIDTH-bit words on a valid/ready
//            handshake and drives one bit per clock onto a single serial
//            line. A one-word pending buffer lets back-to-back words stream
//            out with no idle gap between them. When there is no data, the
//            line sits at IDLE_BIT.
//
// Parameters:
//   WIDTH       bits per input word (2..32)
//   MSB_FIRST   1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//   IDLE_BIT    level on `out` whenever no word is being shifted
//
// Ports:
//   clk          in   1      system clock, rising-edge active
//   reset        in   1      synchronous active-high reset
//   in_data      in   WIDTH  parallel word to serialize
//   in_valid     in   1      in_data is valid this cycle
//   in_ready     out  1      block can accept a word this cycle
//   out          out  1      serial bit stream (detector `in`)
//   out_valid    out  1      `out` carries a data bit, not idle fill
//   frame_start  out  1      first bit of a word is on `out`
//   busy         out  1      shifting, or a pending word is held
//
// Revision : 1.0  initial release
// ============================================================================
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int                c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // State encoding
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    // Registered state
    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_sreg;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_pend;
    logic               r_pend_full;

    // Combinational next-state and helpers
    logic [0:0]         w_state_nxt;
    logic [WIDTH-1:0]   w_sreg_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_load;
    logic               w_accept;
    logic               w_shifting;
    logic [WIDTH-1:0]   w_sreg_shifted;
    logic               w_out_bit;

    // ------------------------------------------------------------------
    // Bit ordering: the output end of the shift register is bit WIDTH-1
    // for MSB-first and bit 0 for LSB-first; each shift moves the next
    // bit into that position.
    // ------------------------------------------------------------------
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_out_bit      = r_sreg[WIDTH-1];
            assign w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_out_bit      = r_sreg[0];
            assign w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake. Ready depends only on the pending flag and reset, so
    // there is no combinational path from in_valid to in_ready. Because
    // ready is low while a word is pending, a load (which needs a pending
    // word) and an accept (which needs an empty buffer) never coincide.
    // ------------------------------------------------------------------
    assign in_ready = !r_pend_full && !reset;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pend      <= in_data;
            r_pend_full <= 1'b1;
        end else if (w_load) begin
            r_pend_full <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (r_pend_full) begin
                    w_load      = 1'b1;
                    w_sreg_nxt  = r_pend;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_st_shift;
                end
            end

            c_st_shift: begin
                if (r_cnt != c_cnt_last) begin
                    w_sreg_nxt = w_sreg_shifted;
                    w_cnt_nxt  = r_cnt + c_cnt_one;
                end else if (r_pend_full) begin
                    // Last bit of this word: chain straight into the
                    // pending word so the stream stays gapless.
                    w_load     = 1'b1;
                    w_sreg_nxt = r_pend;
                    w_cnt_nxt  = '0;
                end else begin
                    w_state_nxt = c_st_idle;
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only
    // ------------------------------------------------------------------
    assign w_shifting  = (r_state == c_st_shift);
    assign out_valid   = w_shifting;
    assign out         = w_shifting ? w_out_bit : IDLE_BIT;
    assign frame_start = w_shifting && (r_cnt == '0);
    assign busy        = w_shifting || r_pend_full;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serializer
// Purpose  : Directed self-checking bench for bit_serializer. Three
//            instances: default (MSB first, idle 0), LSB first, idle 1.
// Revision : 1.0  initial release
// ============================================================================
module tb_bit_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Instance a: MSB_FIRST=1, IDLE_BIT=0
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_out, a_ov, a_fs, a_busy;
    // Instance b: MSB_FIRST=0, IDLE_BIT=0
    logic [7:0] b_data;
    logic       b_valid, b_ready, b_out, b_ov, b_fs, b_busy;
    // Instance c: MSB_FIRST=1, IDLE_BIT=1
    logic [7:0] c_data;
    logic       c_valid, c_ready, c_out, c_ov, c_fs, c_busy;

    int n_tests = 0;
    int n_fail  = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .out(a_out), .out_valid(a_ov),
        .frame_start(a_fs), .busy(a_busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .out(b_out), .out_valid(b_ov),
        .frame_start(b_fs), .busy(b_busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_dut_c (
        .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid),
        .in_ready(c_ready), .out(c_out), .out_valid(c_ov),
        .frame_start(c_fs), .busy(c_busy)
    );

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Streams n words through instance a with in_valid held while words
    // remain; collects serial bits, frame_start flags, accept count, gaps
    // and "101" detections over the valid bits.
    task automatic drive_words(input int n, input logic [7:0] w0, w1, w2,
                               output logic [23:0] bits, output logic [23:0] fsb,
                               output int nbits, output int nacc, output int gaps,
                               output int det, output bit timeout);
        logic [7:0] words [3];
        int         idx;
        bit         acc;
        bit         started;
        logic [2:0] hist;
        words[0] = w0; words[1] = w1; words[2] = w2;
        bits = '0; fsb = '0; nbits = 0; nacc = 0; gaps = 0; det = 0;
        hist = '0; started = 0; timeout = 1; idx = 0;
        a_data  = words[0];
        a_valid = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            acc = a_valid && a_ready;
            tick();
            if (acc) begin
                nacc++;
                idx++;
                if (idx < n) a_data = words[idx];
                else         a_valid = 1'b0;
            end
            if (a_ov) begin
                bits    = {bits[22:0], a_out};
                fsb     = {fsb[22:0], a_fs};
                nbits++;
                started = 1;
                hist    = {hist[1:0], a_out};
                if (hist == 3'b101) det++;
            end else if (started && nbits < 8 * n) begin
                gaps++;
            end
            if (nbits == 8 * n) begin
                timeout = 0;
                break;
            end
        end
        a_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        a_valid = 1'b0; a_data = '0;
        b_valid = 1'b0; b_data = '0;
        c_valid = 1'b0; c_data = '0;
        tick(); tick();
        n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b expected 0", a_ready); end
        reset = 1'b0;
        #1;
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", a_ready); end
        n_tests++; if (a_out !== 1'b0) begin n_fail++; $display("FAIL reset_out: got %b expected 0", a_out); end
        n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", a_ov); end
        n_tests++; if (a_fs !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b expected 0", a_fs); end
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        n_tests++; if (c_out !== 1'b1) begin n_fail++; $display("FAIL reset_idle1_out: got %b expected 1", c_out); end
    endtask

    task automatic test_single_a5;
        logic [7:0] w;
        w = 8'hA5;
        tick();
        a_data = w; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL a5_ready_pending: got %b expected 0", a_ready); end
        n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL a5_busy_pending: got %b expected 1", a_busy); end
        n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL a5_ov_pending: got %b expected 0", a_ov); end
        tick();
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL a5_ov bit%0d: got %b expected 1", i, a_ov); end
            n_tests++; if (a_out !== w[7-i]) begin n_fail++; $display("FAIL a5_out bit%0d: got %b expected %b", i, a_out, w[7-i]); end
            n_tests++; if (a_fs !== (i == 0)) begin n_fail++; $display("FAIL a5_frame_start bit%0d: got %b expected %b", i, a_fs, (i == 0)); end
            tick();
        end
        n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL a5_ov_after: got %b expected 0", a_ov); end
        n_tests++; if (a_out !== 1'b0) begin n_fail++; $display("FAIL a5_out_after: got %b expected 0", a_out); end
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy_after: got %b expected 0", a_busy); end
    endtask

    task automatic test_back_to_back;
        logic [23:0] bits, fsb;
        int nbits, nacc, gaps, det;
        bit to;
        drive_words(2, 8'h05, 8'hFF, 8'h00, bits, fsb, nbits, nacc, gaps, det, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout: got %0d bits expected 16", nbits); end
        n_tests++; if (bits[15:0] !== 16'h05FF) begin n_fail++; $display("FAIL b2b_stream: got %h expected 05ff", bits[15:0]); end
        n_tests++; if (fsb[15:0] !== 16'h8080) begin n_fail++; $display("FAIL b2b_frame_start: got %h expected 8080", fsb[15:0]); end
        n_tests++; if (gaps !== 0) begin n_fail++; $display("FAIL b2b_gaps: got %0d expected 0", gaps); end
        n_tests++; if (nacc !== 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 2", nacc); end
        n_tests++; if (det !== 1) begin n_fail++; $display("FAIL b2b_detect101: got %0d expected 1", det); end
        tick();
        n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL b2b_ov_after: got %b expected 0", a_ov); end
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after: got %b expected 0", a_busy); end
    endtask

    task automatic test_stall;
        logic [23:0] bits, fsb;
        int nbits, nacc, gaps, det;
        bit to;
        drive_words(3, 8'h3C, 8'h96, 8'hE1, bits, fsb, nbits, nacc, gaps, det, to);
        n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: got %0d bits expected 24", nbits); end
        n_tests++; if (bits !== 24'h3C96E1) begin n_fail++; $display("FAIL stall_stream: got %h expected 3c96e1", bits); end
        n_tests++; if (fsb !== 24'h808080) begin n_fail++; $display("FAIL stall_frame_start: got %h expected 808080", fsb); end
        n_tests++; if (gaps !== 0) begin n_fail++; $display("FAIL stall_gaps: got %0d expected 0", gaps); end
        n_tests++; if (nacc !== 3) begin n_fail++; $display("FAIL stall_accepts: got %0d expected 3", nacc); end
        tick();
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy_after: got %b expected 0", a_busy); end
    endtask

    task automatic test_lsb_first;
        logic [7:0] words [2];
        logic [7:0] w;
        words[0] = 8'h01; words[1] = 8'hB4;
        for (int k = 0; k < 2; k++) begin
            w = words[k];
            b_data = w; b_valid = 1'b1;
            tick();
            b_valid = 1'b0;
            tick();
            for (int i = 0; i < 8; i++) begin
                n_tests++; if (b_ov !== 1'b1) begin n_fail++; $display("FAIL lsb_ov w%0d bit%0d: got %b expected 1", k, i, b_ov); end
                n_tests++; if (b_out !== w[i]) begin n_fail++; $display("FAIL lsb_out w%0d bit%0d: got %b expected %b", k, i, b_out, w[i]); end
                n_tests++; if (b_fs !== (i == 0)) begin n_fail++; $display("FAIL lsb_frame_start w%0d bit%0d: got %b expected %b", k, i, b_fs, (i == 0)); end
                tick();
            end
            n_tests++; if (b_ov !== 1'b0) begin n_fail++; $display("FAIL lsb_ov_after w%0d: got %b expected 0", k, b_ov); end
        end
    endtask

    task automatic test_idle_bit;
        n_tests++; if (c_out !== 1'b1 || c_ov !== 1'b0) begin n_fail++; $display("FAIL idle1_quiet: got out=%b ov=%b expected out=1 ov=0", c_out, c_ov); end
        c_data = 8'h00; c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
        n_tests++; if (c_out !== 1'b1) begin n_fail++; $display("FAIL idle1_pending_out: got %b expected 1", c_out); end
        tick();
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (c_ov !== 1'b1 || c_out !== 1'b0) begin n_fail++; $display("FAIL idle1_data bit%0d: got out=%b ov=%b expected out=0 ov=1", i, c_out, c_ov); end
            tick();
        end
        n_tests++; if (c_ov !== 1'b0 || c_out !== 1'b1) begin n_fail++; $display("FAIL idle1_after: got out=%b ov=%b expected out=1 ov=0", c_out, c_ov); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] w;
        w = 8'hC3;
        a_data = w; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (a_out !== w[7-i]) begin n_fail++; $display("FAIL mid_out bit%0d: got %b expected %b", i, a_out, w[7-i]); end
            // Queue a second word so the reset also has a pending word to drop.
            if (i == 0) begin a_data = 8'hFF; a_valid = 1'b1; end
            else        a_valid = 1'b0;
            tick();
        end
        n_tests++; if (a_out !== w[4] || a_ov !== 1'b1) begin n_fail++; $display("FAIL mid_bit3: got out=%b ov=%b expected out=%b ov=1", a_out, a_ov, w[4]); end
        reset = 1'b1;
        tick();
        n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ov: got %b expected 0", a_ov); end
        n_tests++; if (a_out !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out: got %b expected 0", a_out); end
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", a_busy); end
        reset = 1'b0;
        #1;
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", a_ready); end
        tick(); tick();
        n_tests++; if (a_ov !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_resume: got ov=%b busy=%b expected 0 0", a_ov, a_busy); end
        w = 8'h80;
        a_data = w; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (a_ov !== 1'b1 || a_out !== w[7-i]) begin n_fail++; $display("FAIL mid_0x80 bit%0d: got out=%b ov=%b expected out=%b ov=1", i, a_out, a_ov, w[7-i]); end
            tick();
        end
        n_tests++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL mid_0x80_after: got %b expected 0", a_ov); end
    endtask

    task automatic test_valid_during_reset;
        reset = 1'b1;
        a_data = 8'hFF; a_valid = 1'b1;
        #1;
        n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL vr_ready: got %b expected 0", a_ready); end
        tick(); tick();
        n_tests++; if (a_ready !== 1'b0 || a_ov !== 1'b0) begin n_fail++; $display("FAIL vr_in_reset: got ready=%b ov=%b expected 0 0", a_ready, a_ov); end
        reset = 1'b0;
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (a_ov !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL vr_nothing_captured cyc%0d: got ov=%b busy=%b expected 0 0", i, a_ov, a_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_stall();
        test_lsb_first();
        test_idle_bit();
        test_reset_mid();
        test_valid_during_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
